cache_fill_fsm: RTL and testbench
=================================

Name: cache_fill_fsm

Overview:
- Miss-handling controller for the cache data/tag arrays: on a cache miss it fetches an 8-word block (16-bit words) from the pipelined main memory and writes each returned word into the correct word slot of the selected cache line.
- Sits between the cache lookup logic and the main memory model, and drives the 3-bit word-select field into the 3-to-8 wordline decoder of the data array.
- Stalls the pipeline while the fill is in progress.

Parameters:
ADDR_W, 16, byte address width
DATA_W, 16, memory/cache word width
(Block size is fixed at 8 words / 16 bytes; not parameterised.)

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous reset, active-high
miss_detected  input  1  cache lookup missed this cycle
miss_address  input  ADDR_W  byte address of the missing access
memory_data_valid  input  1  memory_data holds a returned word this cycle
memory_data  input  DATA_W  word returned by memory
fsm_busy  output  1  fill in progress; pipeline stall
mem_read_en  output  1  issue a read to memory this cycle
memory_address  output  ADDR_W  byte address of the issued read
write_data_array  output  1  write data_out into the data array this cycle
word_sel  output  3  word index of the current write
word_wordline  output  8  one-hot decode of word_sel, gated by write_data_array
data_out  output  DATA_W  word to write (memory_data passthrough)
write_tag_array  output  1  one-cycle pulse to write tag/valid for the filled line

Behaviour:
- Single clock. Reset is synchronous and active-high on rst, with clock clk.
- Reset values:
  - state = IDLE; issue_cnt = 0; recv_cnt = 0; base_addr = 0.
  - All outputs 0, except the data_out passthrough.
- States: IDLE, FILL.
- IDLE:
  - fsm_busy = miss_detected (combinational, so the pipeline stalls in the miss cycle).
  - On miss_detected: latch base_addr = {miss_address[ADDR_W-1:4], 4'h0}; clear both counters; go to FILL.
  - No memory read is issued in the miss cycle.
  - memory_data_valid is ignored.
- FILL: fsm_busy = 1.
  - Issue side:
    - mem_read_en = 1 while issue_cnt < 8.
    - memory_address = base_addr + {issue_cnt, 1'b0}.
    - issue_cnt increments each cycle mem_read_en is high and saturates at 8.
    - One request per cycle: 8 consecutive cycles, starting the first cycle in FILL.
  - Receive side: each cycle memory_data_valid = 1:
    - write_data_array = 1, data_out = memory_data, word_sel = recv_cnt[2:0].
    - word_wordline = one-hot(word_sel); 8'h00 whenever write_data_array = 0.
    - recv_cnt increments.
  - Words are assumed to return in issue order. Memory latency is arbitrary (≥1 cycle) and is never hard-coded.
  - Issue and receive may occur in the same cycle; the two counters are independent.
  - Last word: when memory_data_valid is high and recv_cnt == 7:
    - write_tag_array = 1 in the same cycle as the final data write.
    - Next state = IDLE.
    - fsm_busy drops the following cycle, unless a new miss_detected is present.
- miss_detected during FILL is ignored. The pipeline is stalled, so the same miss re-presents after the fill and hits.
- memory_data_valid while recv_cnt == 8 cannot occur (the FSM has already left FILL). In IDLE it is ignored.
- rst asserted mid-fill aborts the fill:
  - Next cycle is in IDLE with all outputs 0.
  - No write_tag_array pulse, so the line stays invalid.
- Address arithmetic wraps modulo 2^ADDR_W. Base alignment guarantees no carry out of bits [3:0].
- All counters and state are registered. Outputs are combinational from state, counters and inputs.

Test Plan:
- Fill with 4-cycle memory latency: miss_address = 16'h1236 →
  - Reads issued at 16'h1230, 1232, …, 123E on 8 consecutive cycles.
  - Word writes with word_wordline 8'h01 through 8'h80, in order.
  - write_tag_array high for exactly 1 cycle, coincident with the 8'h80 write.
  - fsm_busy high for 1 (miss cycle) + 12 cycles.
- 1-cycle latency: the data write overlaps the issue stream; fsm_busy total = 10 cycles; each word_sel value appears exactly once.
- Back-to-back misses:
  - Miss at 16'h0000, then miss_detected held high at 16'h0010 after the first fill completes.
  - The second fill starts the cycle after write_tag_array.
  - Addresses 16'h0010–001E.
- Spurious inputs:
  - memory_data_valid pulsed in IDLE → no write_data_array, word_wordline stays 8'h00.
  - miss_detected toggled during FILL → no restart; address sequence unchanged.
- Reset after 5 words received:
  - Next cycle: state IDLE, fsm_busy = 0, mem_read_en = 0, no write_tag_array.
  - A subsequent miss restarts from word 0.
- Address wrap: miss_address = 16'hFFF4 → requests 16'hFFF0–FFFE; no carry into the upper bits.

Source files
------------

// File: rtl/cache_fill_fsm.sv
// cache_fill_fsm
// ---------------------------------------------------------------------------
// Miss-handling controller for the cache data/tag arrays. When a miss is
// reported, it fetches the 8-word (16-byte) block that holds the missing
// address from the pipelined main memory. It writes each returned word into
// its word slot of the selected line, and it pulses the tag write after the
// last word. The pipeline is stalled for the whole fill.
//
// Ports:
//   clk               rising-edge clock
//   rst               synchronous reset, active-high
//   miss_detected     cache lookup missed this cycle
//   miss_address      byte address of the missing access
//   memory_data_valid memory_data holds a returned word this cycle
//   memory_data       word returned by memory
//   fsm_busy          fill in progress (pipeline stall)
//   mem_read_en       issue a read to memory this cycle
//   memory_address    byte address of the issued read (0 when not reading)
//   write_data_array  write data_out into the data array this cycle
//   word_sel          word index of the current write
//   word_wordline     one-hot decode of word_sel, gated by write_data_array
//   data_out          word to write (memory_data passthrough)
//   write_tag_array   one-cycle pulse to write tag/valid for the filled line
// ---------------------------------------------------------------------------
module cache_fill_fsm #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              miss_detected,
  input  logic [ADDR_W-1:0] miss_address,
  input  logic              memory_data_valid,
  input  logic [DATA_W-1:0] memory_data,
  output logic              fsm_busy,
  output logic              mem_read_en,
  output logic [ADDR_W-1:0] memory_address,
  output logic              write_data_array,
  output logic [2:0]        word_sel,
  output logic [7:0]        word_wordline,
  output logic [DATA_W-1:0] data_out,
  output logic              write_tag_array
);

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_t;

  state_t            state_reg, state_next;
  // The counters are 4 bits wide so that they can hold the value 8, which
  // means "all requests issued" or "all words received".
  logic [3:0]        issue_cnt_reg, issue_cnt_next;
  logic [3:0]        recv_cnt_reg, recv_cnt_next;
  logic [ADDR_W-1:0] base_addr_reg, base_addr_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      issue_cnt_reg <= 4'd0;
      recv_cnt_reg  <= 4'd0;
      base_addr_reg <= '0;
    end else begin
      state_reg     <= state_next;
      issue_cnt_reg <= issue_cnt_next;
      recv_cnt_reg  <= recv_cnt_next;
      base_addr_reg <= base_addr_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    issue_cnt_next   = issue_cnt_reg;
    recv_cnt_next    = recv_cnt_reg;
    base_addr_next   = base_addr_reg;
    fsm_busy         = 1'b0;
    mem_read_en      = 1'b0;
    memory_address   = '0;
    write_data_array = 1'b0;
    word_sel         = 3'd0;
    write_tag_array  = 1'b0;

    case (state_reg)
      IDLE: begin
        // Stall in the miss cycle itself. No read is issued until FILL.
        fsm_busy = miss_detected;
        if (miss_detected) begin
          base_addr_next = miss_address & {{(ADDR_W-4){1'b1}}, 4'h0};
          issue_cnt_next = 4'd0;
          recv_cnt_next  = 4'd0;
          state_next     = FILL;
        end
      end

      FILL: begin
        fsm_busy = 1'b1;
        // The issue side runs at one request per cycle. It is independent of
        // the returns, so any memory latency of one cycle or more works.
        if (issue_cnt_reg < 4'd8) begin
          mem_read_en    = 1'b1;
          memory_address = base_addr_reg
                         + {{(ADDR_W-4){1'b0}}, issue_cnt_reg[2:0], 1'b0};
          issue_cnt_next = issue_cnt_reg + 4'd1;
        end
        // Words return in issue order, so the receive count is the word slot.
        if (memory_data_valid) begin
          write_data_array = 1'b1;
          word_sel         = recv_cnt_reg[2:0];
          recv_cnt_next    = recv_cnt_reg + 4'd1;
          if (recv_cnt_reg == 4'd7) begin
            write_tag_array = 1'b1;
            state_next      = IDLE;
          end
        end
      end

      default: state_next = IDLE;
    endcase
  end

  assign data_out = memory_data;

  // 3-to-8 wordline decode. Every line is held low unless a write is active.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_wordline
      assign word_wordline[gi] = write_data_array && (word_sel == 3'(gi));
    end
  endgenerate

endmodule

// File: tb/tb_cache_fill_fsm.sv
module tb_cache_fill_fsm;

  logic        clk = 1'b0;
  logic        rst;
  logic        miss_detected;
  logic [15:0] miss_address;
  logic        memory_data_valid;
  logic [15:0] memory_data;
  logic        fsm_busy;
  logic        mem_read_en;
  logic [15:0] memory_address;
  logic        write_data_array;
  logic [2:0]  word_sel;
  logic [7:0]  word_wordline;
  logic [15:0] data_out;
  logic        write_tag_array;

  cache_fill_fsm #(.ADDR_W(16), .DATA_W(16)) dut (
    .clk               (clk),
    .rst               (rst),
    .miss_detected     (miss_detected),
    .miss_address      (miss_address),
    .memory_data_valid (memory_data_valid),
    .memory_data       (memory_data),
    .fsm_busy          (fsm_busy),
    .mem_read_en       (mem_read_en),
    .memory_address    (memory_address),
    .write_data_array  (write_data_array),
    .word_sel          (word_sel),
    .word_wordline     (word_wordline),
    .data_out          (data_out),
    .write_tag_array   (write_tag_array)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- reference model: one fill as a transaction ------------
  bit          m_active;
  logic [15:0] m_base;
  int          m_issued;
  int          m_recv;

  // Memory model: in-order returns, each at least lat_min cycles after issue.
  int          q_ready[$];
  logic [15:0] q_data[$];
  int          cyc = 0;
  int          last_ready = 0;
  int          lat_min = 1;
  int          lat_max = 1;
  int          busy_cnt, tag_cnt;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return a ^ 16'hC3A5;
  endfunction

  task automatic model_reset();
    m_active = 0; m_base = 16'h0; m_issued = 0; m_recv = 0;
    q_ready.delete(); q_data.delete();
  endtask

  // One clock cycle: drive at negedge, check 1 time unit later, then update
  // the model at posedge.
  task automatic step(input bit miss_i, input logic [15:0] addr_i, input bit rst_i, input bit spur_i);
    bit          from_q;
    bit          e_busy, e_rd, e_wr, e_tag;
    logic [15:0] e_addr;
    logic [7:0]  e_wl;
    int          r;
    rst = rst_i;
    miss_detected = miss_i;
    miss_address = addr_i;
    from_q = (q_ready.size() > 0) && (q_ready[0] <= cyc);
    if (from_q) begin
      memory_data_valid = 1'b1; memory_data = q_data[0];
    end else begin
      memory_data_valid = spur_i; memory_data = 16'($urandom);
    end
    e_busy = m_active || miss_i;
    e_rd   = m_active && (m_issued < 8);
    e_addr = m_base + 16'(2 * m_issued);
    e_wr   = m_active && memory_data_valid;
    e_wl   = e_wr ? 8'(1 << m_recv) : 8'h00;
    e_tag  = e_wr && (m_recv == 7);
    #1;
    chk("fsm_busy", 32'(fsm_busy), 32'(e_busy));
    chk("mem_read_en", 32'(mem_read_en), 32'(e_rd));
    if (e_rd) chk("memory_address", 32'(memory_address), 32'(e_addr));
    chk("write_data_array", 32'(write_data_array), 32'(e_wr));
    if (e_wr) chk("word_sel", 32'(word_sel), 32'(m_recv));
    chk("word_wordline", 32'(word_wordline), 32'(e_wl));
    chk("write_tag_array", 32'(write_tag_array), 32'(e_tag));
    chk("data_out", 32'(data_out), 32'(memory_data));
    busy_cnt += int'(fsm_busy);
    tag_cnt  += int'(write_tag_array);
    @(posedge clk);
    if (rst_i) begin
      model_reset();
    end else if (!m_active) begin
      if (miss_i) begin
        m_active = 1; m_base = addr_i & 16'hFFF0; m_issued = 0; m_recv = 0;
      end
    end else begin
      if (e_rd) begin
        r = cyc + $urandom_range(lat_max, lat_min);
        if (r <= last_ready) r = last_ready + 1;
        last_ready = r;
        q_ready.push_back(r);
        q_data.push_back(mem_word(e_addr));
        m_issued++;
      end
      if (memory_data_valid) begin
        m_recv++;
        if (m_recv == 8) m_active = 0;
      end
    end
    if (from_q) begin
      void'(q_ready.pop_front());
      void'(q_data.pop_front());
    end
    @(negedge clk);
    cyc++;
  endtask

  // Start a fill at address a and run it to completion. hold_mode sets what
  // miss_detected does during the fill: 0 low, 1 high at hold_addr, 2 random.
  task automatic do_fill(input logic [15:0] a, input int hold_mode,
                         input logic [15:0] hold_addr, input int exp_busy);
    int n = 0;
    busy_cnt = 0; tag_cnt = 0;
    step(1'b1, a, 1'b0, 1'b0);
    while (m_active && n < 80) begin
      case (hold_mode)
        1: step(1'b1, hold_addr, 1'b0, 1'b0);
        2: step(1'($urandom), 16'($urandom), 1'b0, 1'b0);
        default: step(1'b0, 16'h0, 1'b0, 1'b0);
      endcase
      n++;
    end
    chk("fill_timeout", 32'(m_active), 32'd0);
    chk("tag_pulses", 32'(tag_cnt), 32'd1);
    if (exp_busy > 0) chk("busy_cycles", 32'(busy_cnt), 32'(exp_busy));
    $display("fill miss=%h base=%h busy_cycles=%0d tag_pulses=%0d", a, a & 16'hFFF0, busy_cnt, tag_cnt);
  endtask

  // ---------------- directed vector table ---------------------------------
  typedef struct {
    bit          miss;
    logic [15:0] addr;
    bit          mdv;
    logic [15:0] mdata;
    bit          busy;
    bit          rd;
    logic [15:0] maddr;
    bit          wr;
    logic [2:0]  wsel;
    logic [7:0]  wl;
    bit          tag;
  } vec_t;

  vec_t vecs[6];

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    //            miss addr     mdv mdata    busy rd maddr    wr wsel wl    tag
    vecs[0] = '{1'b0, 16'h0000, 1'b1, 16'h1111, 1'b0, 1'b0, 16'h0000, 1'b0, 3'd0, 8'h00, 1'b0};
    vecs[1] = '{1'b1, 16'h1236, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 3'd0, 8'h00, 1'b0};
    vecs[2] = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h1230, 1'b0, 3'd0, 8'h00, 1'b0};
    vecs[3] = '{1'b1, 16'hABCD, 1'b1, 16'h2222, 1'b1, 1'b1, 16'h1232, 1'b1, 3'd0, 8'h01, 1'b0};
    vecs[4] = '{1'b0, 16'h0000, 1'b1, 16'h3333, 1'b1, 1'b1, 16'h1234, 1'b1, 3'd1, 8'h02, 1'b0};
    vecs[5] = '{1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b1, 16'h1236, 1'b0, 3'd0, 8'h00, 1'b0};

    rst = 1'b1; miss_detected = 1'b0; miss_address = 16'h0;
    memory_data_valid = 1'b0; memory_data = 16'h0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_busy", 32'(fsm_busy), 32'd0);
    chk("reset_rd", 32'(mem_read_en), 32'd0);
    chk("reset_addr", 32'(memory_address), 32'd0);
    chk("reset_wr", 32'(write_data_array), 32'd0);
    chk("reset_wl", 32'(word_wordline), 32'd0);
    chk("reset_tag", 32'(write_tag_array), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      miss_detected = vecs[i].miss; miss_address = vecs[i].addr;
      memory_data_valid = vecs[i].mdv; memory_data = vecs[i].mdata;
      #1;
      chk($sformatf("vec%0d_busy", i), 32'(fsm_busy), 32'(vecs[i].busy));
      chk($sformatf("vec%0d_rd", i), 32'(mem_read_en), 32'(vecs[i].rd));
      if (vecs[i].rd) chk($sformatf("vec%0d_addr", i), 32'(memory_address), 32'(vecs[i].maddr));
      chk($sformatf("vec%0d_wr", i), 32'(write_data_array), 32'(vecs[i].wr));
      if (vecs[i].wr) chk($sformatf("vec%0d_wsel", i), 32'(word_sel), 32'(vecs[i].wsel));
      chk($sformatf("vec%0d_wl", i), 32'(word_wordline), 32'(vecs[i].wl));
      chk($sformatf("vec%0d_tag", i), 32'(write_tag_array), 32'(vecs[i].tag));
      chk($sformatf("vec%0d_dout", i), 32'(data_out), 32'(vecs[i].mdata));
      $display("vector %0d miss=%b addr=%h mdv=%b", i, vecs[i].miss, vecs[i].addr, vecs[i].mdv);
      @(negedge clk);
    end

    // Abandon the table's fill with a plain reset, then start the model.
    rst = 1'b1; miss_detected = 1'b0; memory_data_valid = 1'b0;
    repeat (2) @(negedge clk);
    model_reset();
    step(1'b0, 16'h0, 1'b1, 1'b0);

    // 4-cycle latency: busy for the miss cycle plus 12 fill cycles.
    lat_min = 4; lat_max = 4;
    do_fill(16'h1236, 0, 16'h0, 13);
    // 1-cycle latency: returns overlap the issue stream.
    lat_min = 1; lat_max = 1;
    step(1'b0, 16'h0, 1'b0, 1'b0);
    do_fill(16'h5678, 0, 16'h0, 10);

    // Back-to-back: the second miss is held during the first fill.
    lat_min = 3; lat_max = 3;
    step(1'b0, 16'h0, 1'b0, 1'b0);
    do_fill(16'h0000, 1, 16'h0010, 0);
    do_fill(16'h0010, 0, 16'h0, 0);

    // Spurious memory_data_valid in IDLE, and miss toggling during FILL.
    repeat (3) step(1'b0, 16'h0, 1'b0, 1'b1);
    lat_min = 1; lat_max = 5;
    do_fill(16'h2A5C, 2, 16'h0, 0);

    // Reset after 5 words received, then restart the fill from word 0.
    lat_min = 2; lat_max = 2;
    step(1'b0, 16'h0, 1'b0, 1'b0);
    tag_cnt = 0;
    step(1'b1, 16'h3450, 1'b0, 1'b0);
    n = 0;
    while (m_recv < 5 && n < 40) begin
      step(1'b0, 16'h0, 1'b0, 1'b0);
      n++;
    end
    chk("abort_reach5", 32'(m_recv), 32'd5);
    step(1'b0, 16'h0, 1'b1, 1'b0);
    step(1'b0, 16'h0, 1'b0, 1'b0);
    chk("abort_no_tag", 32'(tag_cnt), 32'd0);
    $display("fill miss=3450 aborted by reset after %0d words", n > 0 ? 5 : 0);
    do_fill(16'h3450, 0, 16'h0, 0);

    // Address wrap at the top of memory.
    lat_min = 1; lat_max = 3;
    do_fill(16'hFFF4, 0, 16'h0, 0);

    // Randomized fills.
    for (int k = 0; k < 20; k++) begin
      lat_min = 1; lat_max = 1 + int'($urandom_range(7, 0));
      n = int'($urandom_range(3, 0));
      for (int j = 0; j < n; j++) step(1'b0, 16'($urandom), 1'b0, 1'($urandom));
      do_fill(16'($urandom), int'($urandom_range(2, 0)), 16'($urandom), 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
